// File: rtl/multiplier_seq_n_pkg.sv
// rtl/multiplier_seq_n_pkg.sv - shared types and helpers for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mult_state_t;

    // Step counter must reach N-1, so it needs room for values 0..N.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multiplier_seq_n_if.sv
// rtl/multiplier_seq_n_if.sv - operand/product handshake bundle for the sequential multiplier
interface multiplier_seq_n_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/multiplier_seq_n_adder.sv
// rtl/multiplier_seq_n_adder.sv - N-bit ripple-carry adder forming the multiplier datapath
module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[N];
endmodule

// File: rtl/multiplier_seq_n.sv
// rtl/multiplier_seq_n.sv - unsigned shift-and-add N x N -> 2N multiplier, one partial product per clock
module multiplier_seq_n #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    multiplier_seq_n_if.slave  bus
);
    import mult_pkg::*;

    localparam int CW = cnt_width(N);

    mult_state_t   state;
    mult_state_t   state_nxt;
    logic [N-1:0]  mcand;
    logic [N-1:0]  acc_hi;
    logic [N-1:0]  acc_lo;
    logic [N-1:0]  sum;
    logic          c_out;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_step;

    adder_n #(.N(N)) u_adder (
        .a     (acc_hi),
        .b     (mcand & {N{acc_lo[0]}}),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    assign accept    = bus.in_valid && (state == S_IDLE);
    assign last_step = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        unique case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The carry lands in acc_hi[N-1] as the 2N+1-bit {c_out, sum, acc_lo} shifts right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= bus.a;
            acc_lo <= bus.b;
            acc_hi <= '0;
            cnt    <= '0;
        end else if (state == S_RUN) begin
            {acc_hi, acc_lo} <= (2*N)'({c_out, sum, acc_lo} >> 1);
            cnt              <= cnt + CW'(1);
        end
    end

    assign bus.product = {acc_hi, acc_lo};
endmodule

// File: tb/tb_multiplier_seq_n.sv
// tb/tb_multiplier_seq_n.sv - directed and randomized checks of multiplier_seq_n at N=8, N=1, N=16
module tb_multiplier_seq_n;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multiplier_seq_n_if #(.N(8))  if8  ();
    multiplier_seq_n_if #(.N(1))  if1  ();
    multiplier_seq_n_if #(.N(16)) if16 ();

    multiplier_seq_n #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    multiplier_seq_n #(.N(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));
    multiplier_seq_n #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if8.a = a; if8.b = b; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        check("in_ready_drop8", if8.in_ready, 1'b0);
        check("busy_rise8", if8.busy, 1'b1);
    endtask

    task automatic wait8(output int lat, output logic leak);
        lat = 0; leak = 1'b0;
        while (!if8.out_valid && lat < 64) begin
            @(posedge clk); #1; lat++;
            if (if8.in_ready) leak = 1'b1;
        end
    endtask

    task automatic release8();
        @(negedge clk); if8.out_ready = 1'b1;
        @(posedge clk); #1; if8.out_ready = 1'b0;
        check("idle_ready8", if8.in_ready, 1'b1);
        check("idle_valid8", if8.out_valid, 1'b0);
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string tag);
        int   lat;
        logic leak;
        start8(a, b);
        wait8(lat, leak);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_prod"}, if8.product, exp);
        check({tag, "_ready_low"}, leak, 1'b0);
        release8();
    endtask

    task automatic mul1(input logic a, input logic b, input logic [1:0] exp, input string tag);
        int lat;
        @(negedge clk);
        if1.a = a; if1.b = b; if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        lat = 0;
        while (!if1.out_valid && lat < 16) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, lat, 1);
        check({tag, "_prod"}, if1.product, exp);
        @(negedge clk); if1.out_ready = 1'b1;
        @(posedge clk); #1; if1.out_ready = 1'b0;
    endtask

    task automatic mul16(input logic [15:0] a, input logic [15:0] b, input string tag);
        int          lat;
        logic [31:0] exp;
        exp = 32'(a) * 32'(b);
        @(negedge clk);
        if16.a = a; if16.b = b; if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        lat = 0;
        while (!if16.out_valid && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, lat, 16);
        check({tag, "_prod"}, if16.product, exp);
        @(negedge clk); if16.out_ready = 1'b1;
        @(posedge clk); #1; if16.out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic leak;
        rst = 1'b1;
        if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.out_ready  = 1'b0;
        if1.in_valid  = 1'b0; if1.a  = '0; if1.b  = '0; if1.out_ready  = 1'b0;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.out_ready = 1'b0;
        #12;
        check("rst_in_ready", if8.in_ready, 1'b1);
        check("rst_out_valid", if8.out_valid, 1'b0);
        check("rst_busy", if8.busy, 1'b0);
        check("rst_product", if8.product, 16'h0000);
        @(negedge clk); rst = 1'b0;

        mul8(8'd13, 8'd11, 16'h008F, "basic");
        mul8(8'd255, 8'd255, 16'hFE01, "max");
        mul8(8'd0, 8'd200, 16'h0000, "zero_a");
        mul8(8'd200, 8'd0, 16'h0000, "zero_b");
        mul8(8'd1, 8'd1, 16'h0001, "one");

        // Backpressure with stray operand pulses during RUN and DONE.
        start8(8'd7, 8'd9);
        @(negedge clk); if8.a = 8'd3; if8.b = 8'd3; if8.in_valid = 1'b1;
        @(negedge clk); if8.in_valid = 1'b0;
        wait8(lat, leak);
        check("bp_reach_done", if8.out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if8.in_valid = (i == 2);
            #6;
            check("bp_hold_prod", if8.product, 16'd63);
            check("bp_hold_valid", if8.out_valid, 1'b1);
        end
        @(negedge clk); if8.in_valid = 1'b0;
        release8();
        @(posedge clk); #1;
        check("bp_no_phantom", if8.busy, 1'b0);

        // Asynchronous reset between edges, just before RUN step 4.
        start8(8'd100, 8'd100);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", if8.out_valid, 1'b0);
        check("mid_rst_busy", if8.busy, 1'b0);
        check("mid_rst_ready", if8.in_ready, 1'b1);
        check("mid_rst_prod", if8.product, 16'h0000);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        mul8(8'd5, 8'd6, 16'd30, "post_rst");

        mul1(1'b0, 1'b0, 2'b00, "n1_00");
        mul1(1'b0, 1'b1, 2'b00, "n1_01");
        mul1(1'b1, 1'b0, 2'b00, "n1_10");
        mul1(1'b1, 1'b1, 2'b01, "n1_11");

        mul16(16'hFFFF, 16'hFFFF, "n16_max");
        for (int i = 0; i < 1000; i++) begin
            mul16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), "n16_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
